msk_scan_seq: RTL and testbench
===============================

// Module: msk_scan_seq
// PURPOSE
//  Sequencer for a masked scan-register state bank (mux + enabled register per share,
//  controlled by en/scan_en). Accepts a job via valid/ready, issues one parallel-load
//  cycle, then NROUNDS x SHIFT_LEN scan-shift cycles gated by fresh randomness, then
//  holds the result for output handshake. Sits between the top-level control FSM and
//  the masked state datapath; it touches only control signals, never share data.
// PARAMETERS
//  NROUNDS    10  rounds per job (>=1)
//  SHIFT_LEN  4   scan-shift cycles per round (>=1)
//  RW         clog2(NROUNDS) (min 1): width of round_idx
//  SW         clog2(SHIFT_LEN) (min 1): width of shift_idx
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst_n       in   1   asynchronous reset, active low
//  in_valid    in   1   job request; load data valid on bank in_d
//  in_ready    out  1   job accepted when in_valid & in_ready
//  rnd_valid   in   1   fresh masking randomness available this cycle
//  rnd_ready   out  1   randomness consumed when rnd_valid & rnd_ready
//  reg_en      out  1   bank register enable
//  reg_scan_en out  1   bank mux select: 1 = in_scan, 0 = in_d
//  flush_zero  out  1   forces datapath scan input to zero (flush feature only)
//  round_idx   out  RW  current round, 0..NROUNDS-1
//  shift_idx   out  SW  current shift cycle within round, 0..SHIFT_LEN-1
//  last_round  out  1   1 while round_idx == NROUNDS-1 in SHIFT
//  out_valid   out  1   bank holds final result
//  out_ready   in   1   result taken when out_valid & out_ready
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, round_idx=0, shift_idx=0; all 1-bit outputs 0
//    except in_ready=1. Reset mid-job aborts immediately; no output handshake follows.
//  - States: IDLE, SHIFT, DONE (+FLUSH with macro). All outputs decoded from state/counters
//    only; in_ready/reg_en/reg_scan_en never combinationally depend on out_ready.
//  - IDLE: in_ready=1, rnd_ready=0. reg_en=in_valid, reg_scan_en=0 (load in same cycle as
//    accept). On accept -> SHIFT, counters cleared.
//  - SHIFT: in_ready=0, reg_scan_en=1, rnd_ready=1, reg_en=rnd_valid. Counters advance only
//    on rnd_valid (stall otherwise; bank holds). shift_idx wraps SHIFT_LEN-1 -> 0 and then
//    round_idx increments. On advance at (NROUNDS-1, SHIFT_LEN-1) -> DONE, counters -> 0.
//  - DONE: reg_en=0, rnd_ready=0, out_valid=1 until out_ready; then -> IDLE (no macro).
//    New job not accepted in DONE, even with simultaneous out_ready & in_valid.
//  - Latency with rnd_valid stuck 1: accept at cycle t, out_valid first high at
//    t+1+NROUNDS*SHIFT_LEN. Each rnd_valid=0 cycle adds exactly one cycle.
//  - Exactly one randomness word consumed per enabled scan cycle: NROUNDS*SHIFT_LEN per job.
//  - Counters use non-power-of-2 compare, never reach NROUNDS / SHIFT_LEN.
// CONFIGURATION
//  MSK_SCAN_SEQ_FLUSH_EN defined: DONE output handshake -> FLUSH; FLUSH runs SHIFT_LEN cycles
//   with reg_en=1, reg_scan_en=1, flush_zero=1, rnd_ready=0 (no randomness stall), busy=1,
//   in_ready=0, then -> IDLE. Clears share remnants from the bank before next job.
//  Undefined: no FLUSH state; flush_zero tied 0; DONE -> IDLE directly.
// TESTING
//  - Reset: rst_n=0 async mid-cycle -> in_ready=1, busy=0, out_valid=0, reg_en=0 at once.
//  - Nominal (NROUNDS=10, SHIFT_LEN=4, rnd_valid=1): accept at t -> reg_en=1,scan_en=0 at t;
//    40 scan cycles; out_valid at t+41; rnd handshakes counted = 40.
//  - Rnd stall: rnd_valid=0 for 3 cycles at shift_idx=2, round 5 -> counters frozen,
//    reg_en=0 those cycles, out_valid at t+44.
//  - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_valid held, in_ready=0,
//    reg_en=0; last_round high exactly during round 9 shifts.
//  - Abort: rst_n low at round 3 -> IDLE; next job full 40 cycles from round 0.
//  - FLUSH_EN: after out handshake -> 4 cycles flush_zero=1, reg_en=1, then in_ready=1.

Source files
------------

// File: rtl/msk_scan_seq.sv
// Control sequencer for a masked scan-register state bank.
// MSK_SCAN_SEQ_FLUSH_EN adds a zero-flush pass after each result handshake.
module msk_scan_seq #(
  parameter int NROUNDS   = 10,
  parameter int SHIFT_LEN = 4,
  parameter int RW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1,
  parameter int SW = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          reg_en,
  output logic          reg_scan_en,
  output logic          flush_zero,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] shift_idx,
  output logic          last_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] round_n;
  logic [SW-1:0] shift_n;
  logic          sh_last;
  logic          rd_last;

  assign sh_last = (shift_idx == SW'(SHIFT_LEN - 1));
  assign rd_last = (round_idx == RW'(NROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      round_idx <= '0;
      shift_idx <= '0;
    end else begin
      state     <= state_n;
      round_idx <= round_n;
      shift_idx <= shift_n;
    end
  end

  always_comb begin
    state_n     = state;
    round_n     = round_idx;
    shift_n     = shift_idx;
    in_ready    = 1'b0;
    rnd_ready   = 1'b0;
    reg_en      = 1'b0;
    reg_scan_en = 1'b0;
    flush_zero  = 1'b0;
    last_round  = 1'b0;
    out_valid   = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        reg_en   = in_valid;
        if (in_valid) begin
          state_n = S_SHIFT;
          round_n = '0;
          shift_n = '0;
        end
      end
      S_SHIFT: begin
        reg_scan_en = 1'b1;
        rnd_ready   = 1'b1;
        reg_en      = rnd_valid;
        last_round  = rd_last;
        // Bank and counters freeze whenever no fresh mask is available.
        if (rnd_valid) begin
          if (sh_last) begin
            shift_n = '0;
            if (rd_last) begin
              round_n = '0;
              state_n = S_DONE;
            end else begin
              round_n = round_idx + 1'b1;
            end
          end else begin
            shift_n = shift_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef MSK_SCAN_SEQ_FLUSH_EN
          state_n = S_FLUSH;
          shift_n = '0;
`else
          state_n = S_IDLE;
`endif
        end
      end
`ifdef MSK_SCAN_SEQ_FLUSH_EN
      S_FLUSH: begin
        reg_en      = 1'b1;
        reg_scan_en = 1'b1;
        flush_zero  = 1'b1;
        if (sh_last) begin
          shift_n = '0;
          state_n = S_IDLE;
        end else begin
          shift_n = shift_idx + 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_msk_scan_seq.sv
// Scoreboard bench for msk_scan_seq: per-job latency, mask count, last_round.
module tb_msk_scan_seq;
  localparam int NR = 10;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       rnd_valid = 1'b1;
  logic       out_ready = 1'b1;
  logic       in_ready, rnd_ready, reg_en, reg_scan_en, flush_zero;
  logic [3:0] round_idx;
  logic [1:0] shift_idx;
  logic       last_round, out_valid, busy;

  msk_scan_seq #(.NROUNDS(NR), .SHIFT_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .reg_en(reg_en), .reg_scan_en(reg_scan_en),
    .flush_zero(flush_zero),
    .round_idx(round_idx), .shift_idx(shift_idx),
    .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int lat;
    int nrnd;
    int nlast;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: tracks the live job and scores it when out_valid rises.
  int   t_acc = 0;
  int   rcnt = 0;
  int   lcnt = 0;
  logic prev_ov = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        t_acc = cyc;
        rcnt  = 0;
        lcnt  = 0;
      end
      if (rnd_valid && rnd_ready) begin
        rcnt++;
        if (last_round) lcnt++;
      end
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - t_acc, e.lat);
          chk("rnd_count", rcnt, e.nrnd);
          chk("last_round_cnt", lcnt, e.nlast);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("timeout_idle", 0, 1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("timeout_out", 0, 1);
  endtask

  task automatic wait_pos(input int r, input int s);
    int n;
    n = 0;
    while (!(busy && round_idx == 4'(r) && shift_idx == 2'(s)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("timeout_pos", 0, 1);
  endtask

  task automatic start_job();
    wait_idle();
    in_valid = 1'b1;
    #1;
    chk("accept_reg_en", int'(reg_en), 1);
    chk("accept_scan_en", int'(reg_scan_en), 0);
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_reg_en", int'(reg_en), 0);
    chk("rst_round_idx", int'(round_idx), 0);
    rst_n = 1'b1;
    tick();

    // Nominal job
    q.push_back('{41, 40, 4});
    start_job();
    wait_out();
    tick();
`ifdef MSK_SCAN_SEQ_FLUSH_EN
    for (int i = 0; i < SL; i++) begin
      chk("flush_zero", int'(flush_zero), 1);
      chk("flush_reg_en", int'(reg_en), 1);
      chk("flush_in_ready", int'(in_ready), 0);
      chk("flush_rnd_ready", int'(rnd_ready), 0);
      tick();
    end
`endif
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_busy", int'(busy), 0);

    // Randomness stall at round 5, shift 2
    q.push_back('{44, 40, 4});
    start_job();
    wait_pos(5, 2);
    rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_reg_en", int'(reg_en), 0);
      chk("stall_shift", int'(shift_idx), 2);
      chk("stall_round", int'(round_idx), 5);
      tick();
    end
    rnd_valid = 1'b1;
    wait_out();
    tick();
    wait_idle();

    // Output backpressure with a pending request
    q.push_back('{41, 40, 4});
    out_ready = 1'b0;
    start_job();
    wait_out();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_reg_en", int'(reg_en), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef MSK_SCAN_SEQ_FLUSH_EN
    chk("no_accept_in_done", int'(flush_zero), 1);
`else
    chk("no_accept_in_done", int'(busy), 0);
`endif
    chk("no_accept_round", int'(round_idx), 0);
    wait_idle();

    // Abort mid-job, then a clean job from round 0
    start_job();
    wait_pos(3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_reg_en", int'(reg_en), 0);
    chk("abort_round", int'(round_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    q.push_back('{41, 40, 4});
    start_job();
    wait_out();
    tick();
    wait_idle();
    repeat (5) tick();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
